rx_frame_recorder: RTL and testbench

Frame-boundary recorder downstream of the receive byte analyser. It watches the per-byte FIFO write strobe and closes a frame once the line has been idle for a programmed number of baud periods. For each closed frame it stores {byte count, millisecond stamp, 0.1 ms stamp} in a small frame-information FIFO. It drives the receive core's 28-bit frame-information output and the frame FIFO status flags, and is read by the control core.

---
 rtl/rx_frame_recorder_if.sv | 26 ++
 rtl/rx_frame_recorder.sv | 92 +++++++++
 tb/tb_rx_frame_recorder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_recorder_if.sv
// rx_frame_recorder_if: receive-core byte strobe, timing stamps and frame FIFO signals
interface rx_frame_recorder_if;
  logic        p_Enable_i;
  logic        n_ByteWe_i;
  logic        BaudSig_i;
  logic [7:0]  FrameGapSet_i;
  logic [3:0]  acqurate_stamp_i;
  logic [11:0] millisecond_stamp_i;
  logic        n_Rd_i;
  logic        n_Clr_i;
  logic [27:0] FrameInfo_o;
  logic        p_Empty_o;
  logic        p_Full_o;
  logic        p_Over_o;
  logic [4:0]  FrameNum_o;
  modport master (
    output p_Enable_i, n_ByteWe_i, BaudSig_i, FrameGapSet_i, acqurate_stamp_i,
           millisecond_stamp_i, n_Rd_i, n_Clr_i,
    input  FrameInfo_o, p_Empty_o, p_Full_o, p_Over_o, FrameNum_o
  );
  modport slave (
    input  p_Enable_i, n_ByteWe_i, BaudSig_i, FrameGapSet_i, acqurate_stamp_i,
           millisecond_stamp_i, n_Rd_i, n_Clr_i,
    output FrameInfo_o, p_Empty_o, p_Full_o, p_Over_o, FrameNum_o
  );
endinterface

// File: rtl/rx_frame_recorder.sv
// rx_frame_recorder: closes frames after an idle baud gap and queues {count, ms, 0.1ms} records
module rx_frame_recorder #(
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  rx_frame_recorder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_n;
  logic [11:0] byte_cnt, byte_n, ms_l, ms_n;
  logic [7:0]  gap_cnt, gap_n;
  logic [3:0]  acq_l, acq_n;
  logic [27:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]  count;
  logic        over;
  logic        byte_ev, close, push, pop, do_push, full;
  logic [8:0]  gap_inc, gap_lim;
  assign byte_ev = !bus.n_ByteWe_i && bus.p_Enable_i;
  assign gap_inc = {1'b0, gap_cnt} + 9'd1;
  assign gap_lim = bus.FrameGapSet_i == 8'd0 ? 9'd1 : {1'b0, bus.FrameGapSet_i};
  assign close = state == COLLECT && bus.p_Enable_i && !byte_ev && bus.BaudSig_i && gap_inc >= gap_lim;
  assign full = count == 5'(DEPTH);
  assign push = close && bus.n_Clr_i;
  assign pop = !bus.n_Rd_i && count != 5'd0 && bus.n_Clr_i;
  // a full FIFO still accepts the push when the head leaves in the same cycle
  assign do_push = push && (!full || pop);
  always_comb begin
    state_n = state;
    byte_n = byte_cnt;
    gap_n = gap_cnt;
    ms_n = ms_l;
    acq_n = acq_l;
    if (!bus.n_Clr_i || !bus.p_Enable_i) begin
      state_n = IDLE;
      byte_n = '0;
      gap_n = '0;
    end else if (byte_ev) begin
      state_n = COLLECT;
      byte_n = state == IDLE ? 12'd1 : (byte_cnt == 12'hFFF ? byte_cnt : byte_cnt + 12'd1);
      gap_n = '0;
      ms_n = bus.millisecond_stamp_i;
      acq_n = bus.acqurate_stamp_i;
    end else if (state == COLLECT && bus.BaudSig_i) begin
      gap_n = gap_inc[7:0];
      state_n = close ? IDLE : COLLECT;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      byte_cnt <= '0;
      gap_cnt <= '0;
      ms_l <= '0;
      acq_l <= '0;
    end else begin
      state <= state_n;
      byte_cnt <= byte_n;
      gap_cnt <= gap_n;
      ms_l <= ms_n;
      acq_l <= acq_n;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {byte_cnt, ms_l, acq_l};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      over <= 1'b0;
    end else if (!bus.n_Clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      over <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + 5'(do_push) - 5'(pop);
      if (push && full && !pop) over <= 1'b1;
    end
  end
  assign bus.FrameInfo_o = count == 5'd0 ? '0 : mem[rd_ptr];
  assign bus.p_Empty_o = count == 5'd0;
  assign bus.p_Full_o = full;
  assign bus.p_Over_o = over;
  assign bus.FrameNum_o = count;
endmodule

// File: tb/tb_rx_frame_recorder.sv
// tb_rx_frame_recorder: scoreboard bench; expected records queued as frames close, compared as popped
module tb_rx_frame_recorder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [27:0] q [$];
  rx_frame_recorder_if bus ();
  rx_frame_recorder #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [27:0] got, input logic [27:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_byte(input logic [11:0] ms, input logic [3:0] acq);
    bus.millisecond_stamp_i = ms;
    bus.acqurate_stamp_i = acq;
    bus.n_ByteWe_i = 1'b0;
    @(negedge clk);
    bus.n_ByteWe_i = 1'b1;
  endtask
  task automatic baud(input int n);
    repeat (n) begin
      bus.BaudSig_i = 1'b1;
      @(negedge clk);
      bus.BaudSig_i = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic pop_one();
    bus.n_Rd_i = 1'b0;
    @(negedge clk);
    bus.n_Rd_i = 1'b1;
  endtask
  task automatic clear();
    bus.n_Clr_i = 1'b0;
    @(negedge clk);
    bus.n_Clr_i = 1'b1;
  endtask
  task automatic drain(input string name);
    while (q.size() > 0) begin
      chk({name, "_head"}, bus.FrameInfo_o, q.pop_front());
      pop_one();
    end
    chk({name, "_empty"}, {27'd0, bus.p_Empty_o}, 28'd1);
    chk({name, "_info0"}, bus.FrameInfo_o, 28'd0);
  endtask
  task automatic check_reset_outputs(input string name);
    chk({name, "_info"}, bus.FrameInfo_o, 28'd0);
    chk({name, "_flags"}, {25'd0, bus.p_Empty_o, bus.p_Full_o, bus.p_Over_o}, 28'b100);
    chk({name, "_num"}, {23'd0, bus.FrameNum_o}, 28'd0);
  endtask
  task automatic test_reset();
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    check_reset_outputs("reset_release");
  endtask
  task automatic test_single_frame();
    bus.FrameGapSet_i = 8'd3;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) send_byte(12'h123, 4'd7);
      else send_byte(12'(i + 40), 4'(i));
      idle(9);
    end
    baud(2);
    chk("single_not_yet", {23'd0, bus.FrameNum_o}, 28'd0);
    bus.BaudSig_i = 1'b1;
    @(negedge clk);
    bus.BaudSig_i = 1'b0;
    q.push_back(28'h0051237);
    chk("single_num", {23'd0, bus.FrameNum_o}, 28'd1);
    chk("single_empty", {27'd0, bus.p_Empty_o}, 28'd0);
    drain("single");
  endtask
  task automatic test_gap_reset();
    bus.FrameGapSet_i = 8'd4;
    send_byte(12'd1, 4'd1);
    baud(3);
    bus.BaudSig_i = 1'b1;
    send_byte(12'd2, 4'd2);
    bus.BaudSig_i = 1'b0;
    chk("gap_coincident", {23'd0, bus.FrameNum_o}, 28'd0);
    baud(3);
    chk("gap_three", {23'd0, bus.FrameNum_o}, 28'd0);
    baud(1);
    q.push_back({12'd2, 12'd2, 4'd2});
    chk("gap_num", {23'd0, bus.FrameNum_o}, 28'd1);
    drain("gap");
  endtask
  task automatic test_overflow();
    bus.FrameGapSet_i = 8'd0;
    for (int k = 0; k < 9; k++) begin
      send_byte(12'(k + 100), 4'(k % 10));
      baud(1);
      if (k < 8) q.push_back({12'd1, 12'(k + 100), 4'(k % 10)});
    end
    chk("ovf_num", {23'd0, bus.FrameNum_o}, 28'd8);
    chk("ovf_full_over", {26'd0, bus.p_Full_o, bus.p_Over_o}, 28'b11);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_order", bus.FrameInfo_o, q.pop_front());
      pop_one();
    end
    chk("ovf_sticky", {27'd0, bus.p_Over_o}, 28'd1);
    clear();
    q.delete();
    check_reset_outputs("ovf_clear");
  endtask
  task automatic test_full_push_pop();
    bus.FrameGapSet_i = 8'd2;
    for (int k = 0; k < 8; k++) begin
      send_byte(12'(k + 200), 4'(k));
      baud(2);
      q.push_back({12'd1, 12'(k + 200), 4'(k)});
    end
    chk("fpp_full", {27'd0, bus.p_Full_o}, 28'd1);
    send_byte(12'd500, 4'd5);
    baud(1);
    chk("fpp_head_before", bus.FrameInfo_o, q.pop_front());
    bus.BaudSig_i = 1'b1;
    bus.n_Rd_i = 1'b0;
    @(negedge clk);
    bus.BaudSig_i = 1'b0;
    bus.n_Rd_i = 1'b1;
    q.push_back({12'd1, 12'd500, 4'd5});
    chk("fpp_num", {23'd0, bus.FrameNum_o}, 28'd8);
    chk("fpp_over", {27'd0, bus.p_Over_o}, 28'd0);
    drain("fpp");
  endtask
  task automatic test_abort_saturation();
    bus.FrameGapSet_i = 8'd2;
    for (int i = 0; i < 3; i++) send_byte(12'd7, 4'd7);
    bus.p_Enable_i = 1'b0;
    idle(2);
    bus.p_Enable_i = 1'b1;
    baud(3);
    chk("abort_none", {23'd0, bus.FrameNum_o}, 28'd0);
    for (int i = 0; i < 4100; i++) begin
      send_byte(12'd999, 4'd9);
      @(negedge clk);
    end
    baud(2);
    q.push_back({12'hFFF, 12'd999, 4'd9});
    chk("sat_num", {23'd0, bus.FrameNum_o}, 28'd1);
    drain("sat");
  endtask
  task automatic test_reset_clear_mid();
    bus.FrameGapSet_i = 8'd2;
    send_byte(12'd1, 4'd1);
    baud(2);
    send_byte(12'd2, 4'd2);
    chk("mid_pre_num", {23'd0, bus.FrameNum_o}, 28'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    baud(3);
    chk("mid_rst_fsm", {23'd0, bus.FrameNum_o}, 28'd0);
    send_byte(12'd3, 4'd3);
    clear();
    baud(3);
    chk("mid_clr_none", {23'd0, bus.FrameNum_o}, 28'd0);
    send_byte(12'd4, 4'd4);
    baud(2);
    q.push_back({12'd1, 12'd4, 4'd4});
    chk("mid_new_num", {23'd0, bus.FrameNum_o}, 28'd1);
    drain("mid");
  endtask
  initial begin
    bus.p_Enable_i = 1'b1;
    bus.n_ByteWe_i = 1'b1;
    bus.BaudSig_i = 1'b0;
    bus.FrameGapSet_i = 8'd3;
    bus.acqurate_stamp_i = 4'd0;
    bus.millisecond_stamp_i = 12'd0;
    bus.n_Rd_i = 1'b1;
    bus.n_Clr_i = 1'b1;
    test_reset();
    test_single_frame();
    test_gap_reset();
    test_overflow();
    test_full_push_pop();
    test_abort_saturation();
    test_reset_clear_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
